// File: rtl/host_link_pkg.sv
// Shared types and constants for the host link controller.
// The TX_CSUM state exists only when HOST_LINK_CSUM_EN is defined.
package host_link_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_READ = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_RUN,
    S_RD_ADDR,
    S_RD_WAIT,
    S_TX_HI,
    S_TX_LO
`ifdef HOST_LINK_CSUM_EN
    , S_TX_CSUM
`endif
  } state_t;

  function automatic logic [1:0] status_of(state_t s);
    case (s)
      S_IDLE:                       return ST_IDLE;
      S_LEN_LO, S_DAT_HI, S_DAT_LO: return ST_LOAD;
      S_RUN:                        return ST_RUN;
      default:                      return ST_READ;
    endcase
  endfunction

endpackage

// File: rtl/host_link_if.sv
// Host link bus: UART byte ports, data-memory port and core status/handshake.
// master = controller side, slave = environment (UART, memory, cores).
interface host_link_if;
  import host_link_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [1:0]        status;
  logic [WORD_W-1:0] com_data_in;
  logic [WORD_W-1:0] com_addr;
  logic              com_wr_en;
  logic [WORD_W-1:0] com_data_out;
  logic              end_process;
  logic              busy;
  logic              rx_overrun;

  modport master (
    input  rx_data, rx_valid, tx_ready, com_data_out, end_process,
    output tx_data, tx_valid, status, com_data_in, com_addr, com_wr_en, busy, rx_overrun
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, com_data_out, end_process,
    input  tx_data, tx_valid, status, com_data_in, com_addr, com_wr_en, busy, rx_overrun
  );

endinterface

// File: rtl/host_link_tx_slot.sv
// Single-entry valid/ready output register for the UART transmit byte.
// A load in the same cycle as an accept replaces the byte without a bubble.
module host_link_tx_slot
  import host_link_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              tx_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid
);

  // NOTE: registers use <= so every flop samples pre-edge values; = would make results depend on block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_data;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/host_link_ctrl.sv
// Host link controller: UART frame -> data-memory load, run the cores, read back and transmit.
// Define HOST_LINK_CSUM_EN to append an 8-bit modular frame checksum byte to the readback stream.
module host_link_ctrl
  import host_link_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int READ_LAT  = 1,
  parameter int RUN_GUARD = 2
) (
  input logic        clk,
  input logic        rst_n,
  host_link_if.master bus
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] GUARD_N  = CNT_W'(RUN_GUARD);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LAT - 1);

  state_t            state, state_nx;
  logic [WORD_W-1:0] len;
  logic [WORD_W-1:0] wcnt;
  logic [BYTE_W-1:0] data_hi;
  logic [BYTE_W-1:0] rd_lo;
  logic [CNT_W-1:0]  tick;
  logic              slot_load;
  logic [BYTE_W-1:0] slot_data;
  logic              tx_fire;
  logic              last_word;
  logic              rx_take;
`ifdef HOST_LINK_CSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  function automatic logic [WORD_W-1:0] addr_of(logic [WORD_W-1:0] w);
    return WORD_W'(w[ADDR_W-1:0]);
  endfunction

  assign tx_fire   = bus.tx_valid && bus.tx_ready;
  assign last_word = (wcnt == len - 1'b1);
  assign rx_take   = (state == S_IDLE) || (state == S_LEN_LO) ||
                     (state == S_DAT_HI) || (state == S_DAT_LO);

  // The final write strobe still belongs to LOAD even though the FSM already sits in RUN.
  assign bus.status = (state == S_RUN && bus.com_wr_en) ? ST_LOAD : status_of(state);
  assign bus.busy   = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing assignment infers a latch.
    state_nx  = state;
    slot_load = 1'b0;
    slot_data = '0;
    case (state)
      S_IDLE:   if (bus.rx_valid) state_nx = S_LEN_LO;
      S_LEN_LO: if (bus.rx_valid)
                  state_nx = ({len[WORD_W-1:BYTE_W], bus.rx_data} == '0) ? S_RUN : S_DAT_HI;
      S_DAT_HI: if (bus.rx_valid) state_nx = S_DAT_LO;
      S_DAT_LO: if (bus.rx_valid) state_nx = last_word ? S_RUN : S_DAT_HI;
      S_RUN: begin
        if (!bus.com_wr_en && tick == GUARD_N && bus.end_process) begin
          if (len == '0) begin
`ifdef HOST_LINK_CSUM_EN
            state_nx  = S_TX_CSUM;
            slot_load = 1'b1;
            slot_data = csum;
`else
            state_nx  = S_IDLE;
`endif
          end else begin
            state_nx = S_RD_ADDR;
          end
        end
      end
      S_RD_ADDR: state_nx = S_RD_WAIT;
      S_RD_WAIT: if (tick == LAT_LAST) begin
        state_nx  = S_TX_HI;
        slot_load = 1'b1;
        slot_data = bus.com_data_out[WORD_W-1:BYTE_W];
      end
      S_TX_HI: if (tx_fire) begin
        state_nx  = S_TX_LO;
        slot_load = 1'b1;
        slot_data = rd_lo;
      end
      S_TX_LO: if (tx_fire) begin
        if (!last_word) begin
          state_nx = S_RD_ADDR;
        end else begin
`ifdef HOST_LINK_CSUM_EN
          state_nx  = S_TX_CSUM;
          slot_load = 1'b1;
          slot_data = csum;
`else
          state_nx  = S_IDLE;
`endif
        end
      end
`ifdef HOST_LINK_CSUM_EN
      S_TX_CSUM: if (tx_fire) state_nx = S_IDLE;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len             <= '0;
      wcnt            <= '0;
      data_hi         <= '0;
      rd_lo           <= '0;
      tick            <= '0;
      bus.com_wr_en   <= 1'b0;
      bus.com_addr    <= '0;
      bus.com_data_in <= '0;
      bus.rx_overrun  <= 1'b0;
    end else begin
      bus.com_wr_en <= 1'b0;

      // Guard and read-latency counts restart on every state change.
      if (state_nx != state)
        tick <= '0;
      else if ((state == S_RUN && !bus.com_wr_en && tick != GUARD_N) || state == S_RD_WAIT)
        tick <= tick + 1'b1;

      case (state)
        S_IDLE: if (bus.rx_valid) begin
          len  <= {bus.rx_data, {BYTE_W{1'b0}}};
          wcnt <= '0;
        end
        S_LEN_LO: if (bus.rx_valid) len[BYTE_W-1:0] <= bus.rx_data;
        S_DAT_HI: if (bus.rx_valid) data_hi <= bus.rx_data;
        S_DAT_LO: if (bus.rx_valid) begin
          bus.com_wr_en   <= 1'b1;
          bus.com_data_in <= {data_hi, bus.rx_data};
          bus.com_addr    <= addr_of(wcnt);
          wcnt            <= wcnt + 1'b1;
        end
        S_RUN: if (state_nx == S_RD_ADDR) begin
          wcnt         <= '0;
          bus.com_addr <= '0;
        end
        S_RD_WAIT: if (state_nx == S_TX_HI) rd_lo <= bus.com_data_out[BYTE_W-1:0];
        S_TX_LO: if (state_nx == S_RD_ADDR) begin
          wcnt         <= wcnt + 1'b1;
          bus.com_addr <= addr_of(wcnt + 1'b1);
        end
        default: ;
      endcase

      if (bus.rx_valid && !rx_take) bus.rx_overrun <= 1'b1;
    end
  end

`ifdef HOST_LINK_CSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      csum <= '0;
    else if (bus.rx_valid && state == S_IDLE)
      csum <= bus.rx_data;
    else if (bus.rx_valid && rx_take)
      csum <= csum + bus.rx_data;
  end
`endif

  host_link_tx_slot u_tx_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (slot_load),
    .load_data (slot_data),
    .tx_ready  (bus.tx_ready),
    .tx_data   (bus.tx_data),
    .tx_valid  (bus.tx_valid)
  );

endmodule
